// File: rtl/arcade_pkg.sv
// Shared types and constants for the arcade front-panel scheduler.
//   arc_state_t : scheduler FSM states
//   BTN_*       : bit positions inside the 5-bit debounced button pulse bus
//   *_BITS      : widths of the panel LED bus, panel grid and per-game score
package arcade_pkg;

    typedef enum logic [1:0] {
        MENU,
        LAUNCH,
        RUN,
        RESULT
    } arc_state_t;

    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_SEL    = 4;

    localparam int unsigned GRID_BITS  = 64;
    localparam int unsigned LED_BITS   = 16;
    localparam int unsigned SCORE_BITS = 8;

endpackage

// File: rtl/arcade_score_table.sv
// Best-score table, one entry (score + valid) per game.
//   clk, rst_n       : clock, synchronous active-low reset (clears all entries)
//   upd_i            : strobe offering score_i as a new result for game idx_i
//   idx_i            : game index for both the read port and the update
//   score_i          : result score offered with upd_i
//   low_is_better_i  : 1 when a lower score is the better one for game idx_i
//   best_o, valid_o  : stored best score / valid flag of game idx_i
//   updated_o        : combinational, high when this strobe replaces the entry
module arcade_score_table
    import arcade_pkg::*;
#(
    parameter int unsigned NUM_GAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upd_i,
    input  logic [2:0]            idx_i,
    input  logic [SCORE_BITS-1:0] score_i,
    input  logic                  low_is_better_i,
    output logic [SCORE_BITS-1:0] best_o,
    output logic                  valid_o,
    output logic                  updated_o
);

    logic [SCORE_BITS*NUM_GAMES-1:0] best_q, best_d;
    logic [NUM_GAMES-1:0]            valid_q, valid_d;
    logic                            better;

    always_comb begin
        best_o  = '0;
        valid_o = 1'b0;
        for (int unsigned g = 0; g < NUM_GAMES; g++) begin
            if (idx_i == 3'(g)) begin
                best_o  = best_q[SCORE_BITS*g +: SCORE_BITS];
                valid_o = valid_q[g];
            end
        end

        // Equal scores are never "better" in either direction.
        better    = low_is_better_i ? (score_i < best_o) : (score_i > best_o);
        updated_o = upd_i && (!valid_o || better);

        best_d  = best_q;
        valid_d = valid_q;
        for (int unsigned g = 0; g < NUM_GAMES; g++) begin
            if (updated_o && (idx_i == 3'(g))) begin
                best_d[SCORE_BITS*g +: SCORE_BITS] = score_i;
                valid_d[g]                         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_q  <= '0;
            valid_q <= '0;
        end else begin
            best_q  <= best_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/arcade_game_scheduler.sv
// Shares one button / LED / 8x8-grid front panel among NUM_GAMES game cores.
// A menu selects a core, which is then sequenced reset -> play -> result; only
// the active core sees buttons, idle cores are held in reset, and a best-score
// table is kept per game.
//   clk, rst_n        : clock, synchronous active-low reset
//   btn_pulse         : one-cycle pulses, [2]=left [3]=right [4]=select
//   game_led_i        : led bus of core g at [16g+:16]
//   game_grid_i       : grid of core g at [64g+:64]
//   game_check_ok_i   : per-core game-complete flag
//   game_score_i      : score of core g at [8g+:8]
//   game_btn_o        : gated button pulses to core g at [5g+:5]
//   game_rst_o        : active-high synchronous reset per core
//   led, grid         : panel outputs (grid bit index {row,col})
//   active_game       : currently selected game index
//   new_record        : last result set a best score
module arcade_game_scheduler
    import arcade_pkg::*;
#(
    parameter int unsigned NUM_GAMES     = 4,
    parameter logic [31:0] IDLE_TIMEOUT  = 32'd1_500_000_000,
    parameter int unsigned LAUNCH_CYCLES = 2,
    parameter logic [7:0]  LOW_IS_BETTER = 8'b0000_0001
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [4:0]                      btn_pulse,
    input  logic [LED_BITS*NUM_GAMES-1:0]   game_led_i,
    input  logic [GRID_BITS*NUM_GAMES-1:0]  game_grid_i,
    input  logic [NUM_GAMES-1:0]            game_check_ok_i,
    input  logic [SCORE_BITS*NUM_GAMES-1:0] game_score_i,
    output logic [5*NUM_GAMES-1:0]          game_btn_o,
    output logic [NUM_GAMES-1:0]            game_rst_o,
    output logic [LED_BITS-1:0]             led,
    output logic [GRID_BITS-1:0]            grid,
    output logic [2:0]                      active_game,
    output logic                            new_record
);

    localparam logic [2:0]  LAST_GAME   = 3'(NUM_GAMES - 1);
    localparam logic [15:0] LAUNCH_LAST = 16'(LAUNCH_CYCLES - 1);

    arc_state_t      state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [31:0]     idle_q, idle_d;
    logic [15:0]     launch_q, launch_d;
    logic            chk_q, chk_d;
    logic            new_record_q, new_record_d;

    logic                  ok_sel;
    logic                  low_sel;
    logic [SCORE_BITS-1:0] score_sel;
    logic [LED_BITS-1:0]   led_sel;
    logic [GRID_BITS-1:0]  grid_sel;
    logic [SCORE_BITS-1:0] best_sel;
    logic                  best_valid;
    logic                  rec_upd;
    logic                  score_upd;
    logic                  any_btn;
    logic                  rise;
    logic                  timed_out;
    logic                  playing;

    // Per-core input mux for the selected game.
    always_comb begin
        ok_sel    = 1'b0;
        low_sel   = 1'b0;
        score_sel = '0;
        led_sel   = '0;
        grid_sel  = '0;
        for (int unsigned g = 0; g < NUM_GAMES; g++) begin
            if (sel_q == 3'(g)) begin
                ok_sel    = game_check_ok_i[g];
                low_sel   = LOW_IS_BETTER[g];
                score_sel = game_score_i[SCORE_BITS*g +: SCORE_BITS];
                led_sel   = game_led_i[LED_BITS*g +: LED_BITS];
                grid_sel  = game_grid_i[GRID_BITS*g +: GRID_BITS];
            end
        end
    end

    assign any_btn   = |btn_pulse;
    assign playing   = (state_q == RUN) || (state_q == RESULT);
    assign rise      = (state_q == RUN) && ok_sel && !chk_q;
    // A pulse in the terminal cycle counts as activity and suppresses the timeout.
    assign timed_out = playing && !any_btn && (idle_q == IDLE_TIMEOUT - 32'd1);

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        launch_d     = launch_q;
        new_record_d = new_record_q;
        score_upd    = 1'b0;

        unique case (state_q)
            MENU: begin
                launch_d = '0;
                if (btn_pulse[BTN_SEL]) begin
                    state_d = LAUNCH;
                end else if (btn_pulse[BTN_LEFT] && !btn_pulse[BTN_RIGHT]) begin
                    sel_d = (sel_q == 3'd0) ? LAST_GAME : sel_q - 3'd1;
                end else if (btn_pulse[BTN_RIGHT] && !btn_pulse[BTN_LEFT]) begin
                    sel_d = (sel_q == LAST_GAME) ? 3'd0 : sel_q + 3'd1;
                end
            end
            LAUNCH: begin
                if (launch_q == LAUNCH_LAST) begin
                    state_d = RUN;
                end else begin
                    launch_d = launch_q + 16'd1;
                end
            end
            RUN: begin
                // Completion takes priority over a simultaneous timeout.
                if (rise) begin
                    state_d      = RESULT;
                    score_upd    = 1'b1;
                    new_record_d = rec_upd;
                end else if (timed_out) begin
                    state_d = MENU;
                end
            end
            RESULT: begin
                if (btn_pulse[BTN_SEL] || timed_out) begin
                    state_d = MENU;
                end
            end
            default: state_d = MENU;
        endcase

        chk_d  = (state_q == LAUNCH) ? 1'b0 : ok_sel;
        idle_d = (any_btn || (state_d != state_q) || !playing) ? '0 : idle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MENU;
            sel_q        <= '0;
            idle_q       <= '0;
            launch_q     <= '0;
            chk_q        <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            idle_q       <= idle_d;
            launch_q     <= launch_d;
            chk_q        <= chk_d;
            new_record_q <= new_record_d;
        end
    end

    arcade_score_table #(
        .NUM_GAMES(NUM_GAMES)
    ) u_score_table (
        .clk             (clk),
        .rst_n           (rst_n),
        .upd_i           (score_upd),
        .idx_i           (sel_q),
        .score_i         (score_sel),
        .low_is_better_i (low_sel),
        .best_o          (best_sel),
        .valid_o         (best_valid),
        .updated_o       (rec_upd)
    );

    // Panel and per-core outputs.
    always_comb begin
        game_rst_o = '1;
        game_btn_o = '0;
        led        = '0;
        grid       = '0;

        if (playing) begin
            led  = led_sel;
            grid = grid_sel;
            for (int unsigned g = 0; g < NUM_GAMES; g++) begin
                if (sel_q == 3'(g)) begin
                    game_rst_o[g] = 1'b0;
                    if (state_q == RUN) begin
                        game_btn_o[5*g +: 5] = btn_pulse;
                    end
                end
            end
        end else begin
            led[15:8] = best_valid ? best_sel : '0;
            for (int unsigned g = 0; g < NUM_GAMES; g++) begin
                led[g] = (sel_q == 3'(g));
                for (int unsigned r = 0; r < 8; r++) begin
                    grid[8*r + g] = (sel_q == 3'(g));
                end
            end
        end
    end

    assign active_game = sel_q;
    assign new_record  = new_record_q;

endmodule

// File: doc/arcade_game_scheduler.md
Name: arcade_game_scheduler

Overview:
Top-level arbiter that shares the arcade's single button/LED/8x8-grid front panel among NUM_GAMES game cores (e.g. connect four, others).
- Runs a menu to select a game.
- Sequences the selected core through reset → play → result.
- Gates button pulses so only the active core sees them; holds inactive cores in reset.
- Muxes the active core's led/grid to the panel and keeps a best-score table per game.

Parameters:
- NUM_GAMES, 4, number of attached game cores (2..8).
- IDLE_TIMEOUT, 32'd1_500_000_000, cycles with no button pulse before returning to menu (30 s @ 50 MHz).
- LAUNCH_CYCLES, 2, cycles the selected core's reset is held in LAUNCH.
- LOW_IS_BETTER, 8'b0000_0001, bit g=1 means a lower score is better for game g.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- btn_pulse  in  5  one-cycle debounced pulses: [2]=left, [3]=right, [4]=select
- game_led_i  in  16*NUM_GAMES  led bus of core g at [16g+:16]
- game_grid_i  in  64*NUM_GAMES  grid of core g at [64g+:64]
- game_check_ok_i  in  NUM_GAMES  core g game-complete flag
- game_score_i  in  8*NUM_GAMES  core g score
- game_btn_o  out  5*NUM_GAMES  gated button pulses to core g
- game_rst_o  out  NUM_GAMES  active-high synchronous reset to each core
- led  out  16  panel LEDs
- grid  out  64  panel grid, bit index {row[2:0],col[2:0]}
- active_game  out  3  selected game index
- new_record  out  1  last result set a best score

Interface (already decided): one clock; reset is synchronous and active-low. Clock port is clk; reset port is rst_n.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=MENU, sel=0, all best scores=0 and invalid, new_record=0, timeout counter=0.
  - game_rst_o = all ones; game_btn_o = 0.
- FSM states: MENU, LAUNCH, RUN, RESULT.
- MENU:
  - btn[2] decrements sel; btn[3] increments sel. Both wrap within 0..NUM_GAMES-1.
  - btn[2] and btn[3] in the same cycle: no move.
  - btn[4] → LAUNCH. Any move pulse in that same cycle is ignored; the current sel is launched.
  - Outputs: grid = column sel fully lit (rows 0-7); led[7:0] = one-hot sel; led[15:8] = best[sel] (0 if invalid).
  - All cores held in reset.
- LAUNCH:
  - game_rst_o[sel]=1 for exactly LAUNCH_CYCLES cycles, then → RUN.
  - Buttons are not forwarded. Outputs are the same as in MENU.
- RUN:
  - game_rst_o[sel]=0; all others stay 1.
  - game_btn_o[sel] = btn_pulse combinationally (zero latency); other cores get 0.
  - led/grid = core sel outputs, combinational mux.
  - Rising edge of game_check_ok_i[sel] (vs. a registered copy cleared in LAUNCH) → RESULT; score is captured the same cycle.
  - Timeout → MENU. If check_ok rises and timeout fires in the same cycle, RESULT wins.
- RESULT:
  - Core sel stays out of reset, but its buttons are gated to 0. led/grid still show core sel.
  - On entry, compare the captured score with best[sel]:
    - update if best[sel] is invalid, or score < best when LOW_IS_BETTER[sel]=1, or score > best when LOW_IS_BETTER[sel]=0;
    - equal scores never update.
  - new_record is set on update, otherwise cleared. It holds until the next RESULT entry or reset.
  - btn[4] or timeout → MENU.
- Timeout counter:
  - 32-bit, cleared on any btn_pulse bit and on every state change; increments otherwise.
  - Fires when it reaches IDLE_TIMEOUT-1. Active in RUN and RESULT only.
- active_game = sel at all times. sel is frozen outside MENU.
- rst_n low in any state: immediate return to the full reset state next cycle. Best scores are lost.

Decomposition:
- Package arcade_pkg:
  - arc_state_t enum (MENU, LAUNCH, RUN, RESULT);
  - BTN_LEFT=2, BTN_RIGHT=3, BTN_SEL=4;
  - GRID_BITS=64, LED_BITS=16, SCORE_BITS=8.
- Sub-module arcade_score_table:
  - NUM_GAMES best/valid registers;
  - update strobe + index + score + low_is_better inputs;
  - outputs best[sel], valid, updated.

Test Plan (IDLE_TIMEOUT=100, NUM_GAMES=4, LAUNCH_CYCLES=2, LOW_IS_BETTER=0001):
1. Reset, then btn[2] once → sel wraps 0→3; led[7:0]=8'b0000_1000; grid bits 3,11,...,59 set; game_rst_o=4'b1111.
2. sel=1, btn[4] → game_rst_o[1]=1 for exactly 2 cycles, then 0 (others stay 1); in RUN a btn[3] pulse appears on game_btn_o[9:5] in the same cycle, game_btn_o for other cores = 0.
3. In RUN, game 0 raises check_ok with score=12 → RESULT, best[0]=12, new_record=1; replay with score 15 → best stays 12, new_record=0; score 9 → best=9, new_record=1.
4. Game 1 (higher-better), scores 20 then 20 → second result leaves new_record=0, best[1]=20.
5. No buttons in RUN for 100 cycles → MENU exactly at cycle 100, game_rst_o=1111; a pulse at cycle 99 restarts the count.
6. rst_n=0 during RUN → next cycle state=MENU, sel=0, best table cleared (MENU led[15:8]=0), game_btn_o=0.
